gf180mcu_fd_sc_mcu7t5v0__clkmon: RTL and testbench

GF180MCU_FD_SC_MCU7T5V0__CLKMON -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__clkmon

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__clkmon_pkg.sv | 14 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__clkmon_edgesync.sv | 31 +++
 rtl/gf180mcu_fd_sc_mcu7t5v0__clkmon.sv | 144 ++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkmon.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkmon_pkg.sv
// Shared definitions for the clock-monitor cell: FSM encoding and synchronizer depth.
package gf180mcu_fd_sc_mcu7t5v0__clkmon_pkg;

  localparam int SYNC_DEPTH   = 2;
  localparam int FLUSH_CYCLES = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } clkmon_state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkmon_edgesync.sv
// Brings the monitored clock into the reference domain and flags its rising edges.
module gf180mcu_fd_sc_mcu7t5v0__clkmon_edgesync
  import gf180mcu_fd_sc_mcu7t5v0__clkmon_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], din};
    hist_d = sync_q[SYNC_DEPTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[SYNC_DEPTH-1] & ~hist_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkmon.sv
// Windowed edge counter that reports how many rising edges of I occurred per
// WIN reference cycles, with dead/slow/fast classification against LO/HI.
module gf180mcu_fd_sc_mcu7t5v0__clkmon
  import gf180mcu_fd_sc_mcu7t5v0__clkmon_pkg::*;
#(
  parameter int WIN   = 256,
  parameter int CNT_W = 8,
  parameter int LO    = 24,
  parameter int HI    = 40
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             I,
  input  logic             EN,
  output logic [CNT_W-1:0] COUNT,
  output logic             VALID,
  output logic             DEAD,
  output logic             SLOW,
  output logic             FAST,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int                WIN_W      = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WIN - 1);
  localparam logic [1:0]        FLUSH_LAST = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  LO_T       = CNT_W'(LO);
  localparam logic [CNT_W-1:0]  HI_T       = CNT_W'(HI);

  clkmon_state_e    state_q, state_d;
  logic [1:0]       flush_q, flush_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             dead_q, dead_d;
  logic             slow_q, slow_d;
  logic             fast_q, fast_d;
  logic             rise;
  logic             cmp_dead, cmp_slow, cmp_fast;

  gf180mcu_fd_sc_mcu7t5v0__clkmon_edgesync u_edgesync (
    .clk   (CLK),
    .rst_n (RN),
    .din   (I),
    .rise  (rise)
  );

  // Classification is taken straight off the live edge counter so the
  // REPORT cycle can register count and flags together.
  assign cmp_dead = (edge_q == '0);
  assign cmp_slow = (edge_q < LO_T);
  assign cmp_fast = (edge_q > HI_T);

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    win_d   = win_q;
    edge_d  = edge_q;
    count_d = count_q;
    dead_d  = dead_q;
    slow_d  = slow_q;
    fast_d  = fast_q;
    valid_d = 1'b0;

    if (!EN) begin
      state_d = ST_IDLE;
      flush_d = '0;
      win_d   = '0;
      edge_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FLUSH;
          flush_d = '0;
          win_d   = '0;
          edge_d  = '0;
        end
        ST_FLUSH: begin
          if (flush_q == FLUSH_LAST) begin
            state_d = ST_MEASURE;
            flush_d = '0;
          end else begin
            flush_d = flush_q + 2'd1;
          end
        end
        ST_MEASURE: begin
          if (rise && (edge_q != CNT_MAX)) begin
            edge_d = edge_q + 1'b1;
          end
          if (win_q == WIN_LAST) begin
            state_d = ST_REPORT;
            win_d   = '0;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
        ST_REPORT: begin
          count_d = edge_q;
          dead_d  = cmp_dead;
          slow_d  = cmp_slow;
          fast_d  = cmp_fast;
          valid_d = 1'b1;
          // An edge seen now opens the next window instead of being lost.
          edge_d  = CNT_W'(rise);
          state_d = ST_MEASURE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      flush_q <= '0;
      win_q   <= '0;
      edge_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      dead_q  <= 1'b0;
      slow_q  <= 1'b0;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      win_q   <= win_d;
      edge_q  <= edge_d;
      count_q <= count_d;
      valid_q <= valid_d;
      dead_q  <= dead_d;
      slow_q  <= slow_d;
      fast_q  <= fast_d;
    end
  end

  assign COUNT = count_q;
  assign VALID = valid_q;
  assign DEAD  = dead_q;
  assign SLOW  = slow_q;
  assign FAST  = fast_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkmon.sv
// Bench for the clock monitor: table-driven periods, hand corner cases, and
// randomized traffic checked against a timeline model of windows and edges.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkmon;

  localparam int WIN  = 256;
  localparam int LO   = 24;
  localparam int HI   = 40;
  localparam int MAXC = 20000;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  logic en  = 1'b0;
  logic i_in = 1'b0;

  logic [7:0] count8;
  logic       valid8, dead8, slow8, fast8;
  logic [5:0] count6;
  logic       valid6, dead6, slow6, fast6;
  wire        vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__clkmon #(.WIN(WIN), .CNT_W(8), .LO(LO), .HI(HI)) u_dut8 (
    .CLK(clk), .RN(rn), .I(i_in), .EN(en),
    .COUNT(count8), .VALID(valid8), .DEAD(dead8), .SLOW(slow8), .FAST(fast8),
    .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__clkmon #(.WIN(WIN), .CNT_W(6), .LO(LO), .HI(HI)) u_dut6 (
    .CLK(clk), .RN(rn), .I(i_in), .EN(en),
    .COUNT(count6), .VALID(valid6), .DEAD(dead6), .SLOW(slow6), .FAST(fast6),
    .VDD(vdd), .VSS(vss)
  );

  typedef struct {
    int   edge_idx;
    int   cnt;
    logic dead;
    logic slow;
    logic fast;
  } obs_t;

  typedef struct {
    int   period;
    int   exp_cnt;
    int   tol;
    logic dead;
    logic slow;
    logic fast;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   i_rec  [MAXC];
  bit   en_rec [MAXC];
  obs_t obs8[$];
  obs_t obs6[$];
  obs_t exp_q[$];
  logic v8_now, v6_now;
  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [31:0] act, input int exp, input int tol);
    n_vec++;
    if ((^act === 1'bx) || (int'(act) < exp - tol) || (int'(act) > exp + tol)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Drive at the falling edge, record what the rising edge samples, observe at the next fall.
  task automatic step(input logic en_v, input logic i_v);
    en   = en_v;
    i_in = i_v;
    @(posedge clk);
    if (cyc < MAXC) begin
      i_rec[cyc]  = i_v;
      en_rec[cyc] = en_v;
    end
    cyc++;
    @(negedge clk);
    v8_now = valid8;
    v6_now = valid6;
    if (valid8) obs8.push_back('{cyc - 1, int'(count8), dead8, slow8, fast8});
    if (valid6) obs6.push_back('{cyc - 1, int'(count6), dead6, slow6, fast6});
  endtask

  // An edge is seen at sample k when I was high two samples back and low three back.
  function automatic int det(input int k);
    bit a, b;
    a = (k >= 2 && k - 2 < MAXC) ? i_rec[k-2] : 1'b0;
    b = (k >= 3 && k - 3 < MAXC) ? i_rec[k-3] : 1'b0;
    return (a && !b) ? 1 : 0;
  endfunction

  // Rebuild every expected report from the recorded EN/I timeline: an enable run
  // starting at e0 reports at e0+4+WIN and then every WIN+1 samples while EN stays high.
  task automatic build_expected(input int upto);
    int k, e0, en_end, r, lo_e, c;
    exp_q.delete();
    k = 0;
    while (k < upto) begin
      if (en_rec[k] && (k == 0 || !en_rec[k-1])) begin
        e0 = k;
        en_end = k;
        while (en_end < upto && en_rec[en_end]) en_end++;
        lo_e = e0 + 4;
        r    = e0 + 4 + WIN;
        while (r < en_end) begin
          c = 0;
          for (int j = lo_e; j < r; j++) c += det(j);
          exp_q.push_back('{r, c, 1'b0, 1'b0, 1'b0});
          lo_e = r;
          r   += WIN + 1;
        end
        k = en_end;
      end else begin
        k++;
      end
    end
  endtask

  task automatic compare_all(input bit sel6, input int maxc);
    obs_t a;
    int   n_act, c;
    string tag;
    tag   = sel6 ? "w6" : "w8";
    n_act = sel6 ? obs6.size() : obs8.size();
    check($sformatf("%s report count", tag), n_act, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_act; i++) begin
      a = sel6 ? obs6[i] : obs8[i];
      c = (exp_q[i].cnt > maxc) ? maxc : exp_q[i].cnt;
      check($sformatf("%s rpt%0d edge", tag, i), a.edge_idx, exp_q[i].edge_idx);
      check($sformatf("%s rpt%0d count", tag, i), a.cnt, c);
      check($sformatf("%s rpt%0d dead", tag, i), a.dead, (c == 0));
      check($sformatf("%s rpt%0d slow", tag, i), a.slow, (c < LO));
      check($sformatf("%s rpt%0d fast", tag, i), a.fast, (c > HI));
    end
  endtask

  initial begin
    int   e0, e1, e2, n8, c8, c6, mid_cnt, nvalid, len, hold, lowlen;
    logic d8, s8, f8, f6, iv;

    vt[0] = '{8,  32, 0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{0,  0,  0, 1'b1, 1'b1, 1'b0};
    vt[2] = '{4,  64, 0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{16, 16, 0, 1'b0, 1'b1, 1'b0};
    vt[4] = '{6,  43, 1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{7,  37, 1, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst count", count8, 0);
    check("rst valid", valid8, 0);
    check("rst dead",  dead8,  0);
    check("rst slow",  slow8,  0);
    check("rst fast",  fast8,  0);
    @(negedge clk);
    rn = 1'b1;

    // Table-driven periods: two reports each
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 4; s++) step(1'b0, 1'b0);
      e0 = cyc; e1 = -1; e2 = -1; n8 = 0; c8 = -1; c6 = -1; mid_cnt = -1;
      d8 = 1'bx; s8 = 1'bx; f8 = 1'bx; f6 = 1'bx;
      for (int s = 0; s < 2 * WIN + 12; s++) begin
        iv = (vt[r].period == 0) ? 1'b0 : ((s % vt[r].period) < vt[r].period / 2);
        step(1'b1, iv);
        if (v8_now) begin
          if (n8 == 0) begin
            e1 = cyc - 1; c8 = int'(count8); d8 = dead8; s8 = slow8; f8 = fast8;
          end else if (n8 == 1) begin
            e2 = cyc - 1;
          end
          n8++;
        end
        if (v6_now && c6 < 0) begin
          c6 = int'(count6); f6 = fast6;
        end
        if (s == WIN + 104) mid_cnt = int'(count8);
      end
      check($sformatf("p%0d first valid edge", vt[r].period), e1, e0 + 4 + WIN);
      check($sformatf("p%0d second valid edge", vt[r].period), e2, e0 + 5 + 2 * WIN);
      check_tol($sformatf("p%0d count", vt[r].period), c8, vt[r].exp_cnt, vt[r].tol);
      check($sformatf("p%0d dead", vt[r].period), d8, vt[r].dead);
      check($sformatf("p%0d slow", vt[r].period), s8, vt[r].slow);
      check($sformatf("p%0d fast", vt[r].period), f8, vt[r].fast);
      check_tol($sformatf("p%0d count held mid-window", vt[r].period), mid_cnt, vt[r].exp_cnt, vt[r].tol);
      if (vt[r].exp_cnt - vt[r].tol >= 63)
        check($sformatf("p%0d w6 saturated count", vt[r].period), c6, 63);
      else
        check_tol($sformatf("p%0d w6 count", vt[r].period), c6, vt[r].exp_cnt, vt[r].tol);
      check($sformatf("p%0d w6 fast", vt[r].period), f6, vt[r].fast);
    end

    // EN dropped at measure cycle 100 of the second window: no report, count held
    for (int s = 0; s < 4; s++) step(1'b0, 1'b0);
    e0 = cyc;
    for (int s = 0; s < WIN + 105; s++) step(1'b1, ((s % 8) < 4));
    nvalid = 0;
    for (int s = 0; s < 300; s++) begin
      step(1'b0, ((s % 8) < 4));
      if (v8_now) nvalid++;
    end
    check("abort no valid", nvalid, 0);
    check("abort count held", count8, 32);
    e0 = cyc; e1 = -1; c8 = -1;
    for (int s = 0; s < WIN + 8; s++) begin
      step(1'b1, 1'b0);
      if (v8_now && e1 < 0) begin e1 = cyc - 1; c8 = int'(count8); end
    end
    check("reenable flush restart edge", e1, e0 + 4 + WIN);
    check("reenable dead count", c8, 0);

    // Edge detected exactly on the report cycle belongs to the next window
    for (int s = 0; s < 4; s++) step(1'b0, 1'b0);
    e0 = cyc; n8 = 0; c8 = -1; e2 = -1;
    for (int s = 0; s < 2 * WIN + 10; s++) begin
      step(1'b1, (s >= WIN + 2));
      if (v8_now) begin
        if (n8 == 0) c8 = int'(count8);
        else if (n8 == 1) begin e2 = int'(count8); s8 = slow8; d8 = dead8; end
        n8++;
      end
    end
    check("report-edge win0 count", c8, 0);
    check("report-edge win1 count", e2, 1);
    check("report-edge win1 dead", d8, 0);
    check("report-edge win1 slow", s8, 1);

    // Randomized traffic with random EN gaps
    iv = 1'b0;
    for (int seg = 0; seg < 6; seg++) begin
      len    = $urandom_range(300, 900);
      lowlen = $urandom_range(1, 3);
      hold   = 0;
      for (int s = 0; s < len; s++) begin
        if (hold == 0) begin
          iv   = ~iv;
          hold = $urandom_range(2, 2 + seg * 3);
        end
        hold--;
        step(1'b1, iv);
      end
      for (int s = 0; s < lowlen; s++) step(1'b0, iv);
    end

    build_expected(cyc);
    compare_all(1'b0, 255);
    compare_all(1'b1, 63);

    // Asynchronous reset mid-window with a nonzero count
    for (int s = 0; s < 4; s++) step(1'b0, 1'b0);
    for (int s = 0; s < WIN + 60; s++) step(1'b1, ((s % 8) < 4));
    check("pre-reset count", count8, 32);
    #2 rn = 1'b0;
    #1;
    check("async rst count", count8, 0);
    check("async rst valid", valid8, 0);
    check("async rst dead",  dead8,  0);
    check("async rst slow",  slow8,  0);
    check("async rst fast",  fast8,  0);
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    rn = 1'b1;
    e0 = cyc; e1 = -1; c8 = -1;
    for (int s = 0; s < WIN + 8; s++) begin
      step(1'b1, ((s % 8) < 4));
      if (v8_now && e1 < 0) begin e1 = cyc - 1; c8 = int'(count8); end
    end
    check("post-reset restart edge", e1, e0 + 4 + WIN);
    check("post-reset count", c8, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
